inhibitor_bank: RTL

Multi-channel, registered successor to the single-bit combinational inhibitor. Each of `WIDTH` channels passes a one-cycle pulse on every accepted rising edge of its input. Each channel is gated by a global active-low enable and a per-channel active-low enable. After each passed pulse, the channel enters a programmable holdoff window during which further edges are dropped. The block sits between raw event/trigger sources and downstream counters or interrupt logic, and suppresses bursts and glitch trains.

---
 rtl/inhibitor_pkg.sv | 15 +
 rtl/inhibitor_channel.sv | 73 +++++++
 rtl/inhibitor_bank.sv | 69 ++++++
 3 files changed

// File: rtl/inhibitor_pkg.sv
// Shared types, default parameters and sizing helper for the inhibitor bank.
package inhibitor_pkg;

  typedef enum logic {INH_IDLE, INH_HOLD} inh_state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_HOLDOFF = 4;
  localparam int unsigned DEF_CNT_W   = 16;

  // Holdoff counter must be able to hold the value HOLDOFF itself.
  function automatic int unsigned holdoff_cnt_w(input int unsigned holdoff);
    return $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/inhibitor_channel.sv
// One inhibitor channel: rising-edge detect, enable gating, holdoff FSM,
// registered one-cycle output pulse, busy flag and a combinational drop strobe.
module inhibitor_channel
  import inhibitor_pkg::*;
#(
  parameter int unsigned HOLDOFF = DEF_HOLDOFF
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic pass,
  output logic out,
  output logic busy,
  output logic drop
);

  localparam int unsigned CntW = holdoff_cnt_w(HOLDOFF);

  logic            prev_q;
  inh_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            rise;

  assign rise = in & ~prev_q;

  // Next-state: accept an edge only when idle and gated open; anything else is a drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      INH_IDLE: begin
        if (rise) begin
          if (pass) begin
            out_d   = 1'b1;
            cnt_d   = CntW'(HOLDOFF);
            state_d = INH_HOLD;
          end else begin
            drop = 1'b1;
          end
        end
      end
      INH_HOLD: begin
        // Gating inputs are ignored here: a running holdoff always completes.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = INH_IDLE;
        drop = rise;
      end
      default: state_d = INH_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      state_q <= INH_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      prev_q  <= in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == INH_HOLD);

endmodule

// File: rtl/inhibitor_bank.sv
// WIDTH independent inhibitor channels with shared global enable.
// Optional feature macro: INHIBITOR_DROP_CNT_EN adds the saturating drop_cnt output.
module inhibitor_bank
  import inhibitor_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned HOLDOFF = DEF_HOLDOFF,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             enable_l,
  input  logic [WIDTH-1:0] chan_en_l,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
`ifdef INHIBITOR_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  logic [WIDTH-1:0] drop;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    inhibitor_channel #(
      .HOLDOFF(HOLDOFF)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .in   (in[i]),
      .pass (~enable_l & ~chan_en_l[i]),
      .out  (out[i]),
      .busy (busy[i]),
      .drop (drop[i])
    );
  end

`ifdef INHIBITOR_DROP_CNT_EN
  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam int unsigned SumW = CNT_W + PopW;

  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  sum;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Count channels dropping an edge this cycle, then add with saturation.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pop = pop + PopW'(drop[i]);
    sum = SumW'(drop_cnt_q) + SumW'(pop);
    if (sum > SumW'({CNT_W{1'b1}})) drop_cnt_d = '1;
    else                            drop_cnt_d = sum[CNT_W-1:0];
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  localparam int unsigned UnusedCntW = CNT_W;
  logic unused_drop;
  assign unused_drop = ^drop;
`endif

endmodule
